// File: rtl/nibble_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit conditional-sum stage reused per nibble, LSB nibble first.
// Optional signed-overflow output V is built only when NSA_OVERFLOW_EN is defined.

module Conditional_sum_adder_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_in,
  output logic [3:0] S,
  output logic       C_out
);

  logic [3:0] s0, s1, c0, c1;
  logic [1:0] lo0_s, lo1_s, hi0_s, hi1_s, lo_s;
  logic       lo0_c, lo1_c, hi0_c, hi1_c, lo_c;

  // Each block precomputes sum/carry for both possible carry-ins, then muxes.
  always_comb begin
    s0 = A ^ B;
    s1 = ~(A ^ B);
    c0 = A & B;
    c1 = A | B;

    lo0_s = {(c0[0] ? s1[1] : s0[1]), s0[0]};
    lo0_c = c0[0] ? c1[1] : c0[1];
    lo1_s = {(c1[0] ? s1[1] : s0[1]), s1[0]};
    lo1_c = c1[0] ? c1[1] : c0[1];
    hi0_s = {(c0[2] ? s1[3] : s0[3]), s0[2]};
    hi0_c = c0[2] ? c1[3] : c0[3];
    hi1_s = {(c1[2] ? s1[3] : s0[3]), s1[2]};
    hi1_c = c1[2] ? c1[3] : c0[3];

    lo_s  = C_in ? lo1_s : lo0_s;
    lo_c  = C_in ? lo1_c : lo0_c;
    S     = {(lo_c ? hi1_s : hi0_s), lo_s};
    C_out = lo_c ? hi1_c : hi0_c;
  end

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out
`ifdef NSA_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q, s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic [3:0]       nib_s;
  logic             nib_co;
  logic [WIDTH-1:0] sum_d;

  Conditional_sum_adder_4bit u_csa (
    .A    (a_sh_q[3:0]),
    .B    (b_sh_q[3:0]),
    .C_in (carry_q),
    .S    (nib_s),
    .C_out(nib_co)
  );

  assign sum_d = {nib_s, sum_sh_q[WIDTH-1:4]};

`ifdef NSA_OVERFLOW_EN
  logic a_msb_q, b_msb_q, v_q;
  assign V = v_q;
`endif

  // S/C_out are a shadow of the working sum, written only on the last nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      v_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= A;
            b_sh_q  <= B;
            carry_q <= C_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef NSA_OVERFLOW_EN
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= B[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> 4;
          b_sh_q   <= b_sh_q >> 4;
          carry_q  <= nib_co;
          sum_sh_q <= sum_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            s_q     <= sum_d;
            cout_q  <= nib_co;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef NSA_OVERFLOW_EN
            v_q     <= a_msb_q ^ b_msb_q ^ nib_s[3] ^ nib_co;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign S     = s_q;
  assign C_out = cout_q;

endmodule
